mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one mem_system instance (cache plus four-bank memory) between the instruction-fetch port and the data port of the processor.
- Accepts one outstanding request per port and grants the memory to one requester at a time.
- Holds the granted request on the memory side until Done, then routes the result back to the owner.
- Includes a watchdog that traps a memory system that never completes.

Parameters:
- TIMEOUT, 64: max cycles a granted transaction may wait for m_Done before the block faults. Must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_Addr  in  16  fetch address
- i_Rd  in  1  fetch request (level; held until i_Done)
- i_DataOut  out  16  fetch read data, valid when i_Done
- i_Done  out  1  fetch complete, one-cycle pulse
- i_Stall  out  1  fetch request pending and not completing this cycle
- i_err  out  1  fetch error
- d_Addr  in  16  data address
- d_DataIn  in  16  store data
- d_Rd  in  1  load request (level; held until d_Done)
- d_Wr  in  1  store request (level; held until d_Done)
- d_DataOut  out  16  load data, valid when d_Done
- d_Done  out  1  data complete, one-cycle pulse
- d_Stall  out  1  data request pending and not completing this cycle
- d_CacheHit  out  1  m_CacheHit forwarded on d_Done
- d_err  out  1  data error
- m_Addr  out  16  to mem_system Addr
- m_DataIn  out  16  to mem_system DataIn
- m_Rd  out  1  to mem_system Rd
- m_Wr  out  1  to mem_system Wr
- m_DataOut  in  16  from mem_system
- m_Done  in  1  from mem_system
- m_Stall  in  1  from mem_system (observational only, not used for control)
- m_CacheHit  in  1  from mem_system
- m_err  in  1  from mem_system

Behaviour:
- Reset: state=IDLE, timeout counter=0, latched addr/data=0. All m_* outputs and requester outputs are 0.
- States: IDLE, BUSY_I, BUSY_D, FAULT.
- IDLE arbitration, sampled on the clock edge:
  - d_Rd&d_Wr both high: illegal. d_err=1 combinationally that cycle; no grant; stay IDLE.
  - else d_Rd|d_Wr: latch d_Addr, d_DataIn, op; go to BUSY_D.
  - else i_Rd: latch i_Addr; go to BUSY_I.
  - Fixed priority is D over I; see the optional feature.
- BUSY_x: m_Addr/m_DataIn/m_Rd/m_Wr are registered from the latched values and held constant for the whole transaction.
  - Earliest m_Rd/m_Wr is the cycle after the grant edge.
  - Requester input changes are ignored while BUSY.
- Completion, on m_Done=1 in BUSY_x:
  - Owner x_Done=1 and x_DataOut=m_DataOut, combinational, same cycle. d_CacheHit=m_CacheHit when owner is D; otherwise 0.
  - m_Rd/m_Wr drop on the next edge; go to IDLE.
  - Next grant occurs no earlier than the edge after IDLE is entered, so there is at least one idle cycle between transactions.
  - Requester drops its request after the Done cycle.
- m_err=1 in BUSY_x: owner x_err=1 that cycle. It is treated as completion (x_Done=1, back to IDLE) even if m_Done=0.
- Stall:
  - i_Stall = i_Rd & ~(state==BUSY_I & m_Done).
  - d_Stall = (d_Rd|d_Wr) & ~(state==BUSY_D & m_Done).
  - High in IDLE for pending requests.
  - The non-owner stalls throughout the other port's transaction.
- Watchdog:
  - Counter clears on entry to BUSY_x and increments each BUSY cycle without m_Done/m_err.
  - When the counter reaches TIMEOUT-1: go to FAULT, drop m_Rd/m_Wr.
- FAULT: i_err=d_err=1 held; i_Done=d_Done=0; both Stalls follow pending requests; exit only by rst.
- Simultaneous m_Done and timeout in the same cycle: completion wins.
- Reset mid-transaction: immediate return to reset values; the latched request is discarded.
- Outputs of the non-owner port: DataOut=0, Done=0, CacheHit=0.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - A last-grant register (reset value: I) alternates when both ports request in IDLE. The port not granted last wins.
  - A single-port request is granted regardless of the register.
  - The register updates on each grant.
- MEM_ARB_RR_EN undefined: fixed D-over-I priority; no last-grant register.

Test Plan:
- Single fetch: i_Rd=1, i_Addr=0x0040, model returns m_Done after 3 cycles with 0xBEEF -> m_Rd high with m_Addr=0x0040; i_Done pulses with i_DataOut=0xBEEF; i_Stall=0 in the Done cycle.
- Collision: i_Rd and d_Wr (d_Addr=0x1000, d_DataIn=0x1234) asserted together -> D granted first with m_Wr=1, m_DataIn=0x1234, i_Stall held; I granted after d_Done plus 1 idle cycle. Under MEM_ARB_RR_EN, a second collision grants I first.
- Illegal op: d_Rd=d_Wr=1 in IDLE -> d_err=1, m_Rd=m_Wr=0, state stays IDLE.
- Memory error: d_Rd granted, model asserts m_err with m_Done=0 -> d_err=1 and d_Done=1 same cycle; returns to IDLE.
- Timeout: TIMEOUT=8, model never completes -> after 8 BUSY cycles m_Rd=0, i_err=d_err=1 held, new requests ignored until rst.
- Async reset: assert rst mid-BUSY_D between clock edges -> all outputs 0 immediately; a post-reset i_Rd is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system (cache + four-bank memory) between the
// instruction-fetch port (i_*) and the data port (d_*). One outstanding
// request per port; one transaction on the memory side at a time. The granted
// request is registered onto m_* and held until m_Done or m_err, and the
// result is routed back to the owner combinationally in the completion cycle.
// A watchdog moves the block to a sticky FAULT state if a granted transaction
// waits TIMEOUT cycles without completing.
//
// Optional feature: define MEM_ARB_RR_EN to alternate grants when both ports
// request in the same idle cycle. When it is undefined, D has fixed priority
// over I.
//
// Parameters:
//   TIMEOUT  busy cycles allowed before FAULT (>= 2)
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_Addr, i_Rd                  fetch request (level, held until i_Done)
//   i_DataOut, i_Done, i_Stall, i_err   fetch response/status
//   d_Addr, d_DataIn, d_Rd, d_Wr  data request (level, held until d_Done)
//   d_DataOut, d_Done, d_Stall, d_CacheHit, d_err   data response/status
//   m_Addr, m_DataIn, m_Rd, m_Wr  request to mem_system (registered)
//   m_DataOut, m_Done, m_Stall, m_CacheHit, m_err   response from mem_system
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_Addr,
  input  logic        i_Rd,
  output logic [15:0] i_DataOut,
  output logic        i_Done,
  output logic        i_Stall,
  output logic        i_err,
  input  logic [15:0] d_Addr,
  input  logic [15:0] d_DataIn,
  input  logic        d_Rd,
  input  logic        d_Wr,
  output logic [15:0] d_DataOut,
  output logic        d_Done,
  output logic        d_Stall,
  output logic        d_CacheHit,
  output logic        d_err,
  output logic [15:0] m_Addr,
  output logic [15:0] m_DataIn,
  output logic        m_Rd,
  output logic        m_Wr,
  input  logic [15:0] m_DataOut,
  input  logic        m_Done,
  input  logic        m_Stall,
  input  logic        m_CacheHit,
  input  logic        m_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, FAULT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   addr_q, addr_nxt;
  logic [15:0]   data_q, data_nxt;
  logic          rd_q, rd_nxt;
  logic          wr_q, wr_nxt;

  logic d_req, illegal, grant_d, grant_i;
  logic busy_i, busy_d, fin;

  // m_Stall carries no control meaning here; it is observed only.
  logic unused_m_stall;
  assign unused_m_stall = m_Stall;

  assign d_req   = d_Rd | d_Wr;
  assign illegal = d_Rd & d_Wr;
  assign busy_i  = (state == BUSY_I);
  assign busy_d  = (state == BUSY_D);
  // m_err ends a transaction just like m_Done does.
  assign fin     = (busy_i | busy_d) & (m_Done | m_err);

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when D received the most recent grant (reset: I last).
  logic last_d, last_d_nxt;

  assign grant_d = (state == IDLE) & d_req & ~illegal & (~i_Rd | ~last_d);
  assign grant_i = (state == IDLE) & i_Rd & ~illegal & (~d_req | last_d);

  always_comb begin
    last_d_nxt = last_d;
    if (grant_d)      last_d_nxt = 1'b1;
    else if (grant_i) last_d_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d <= 1'b0;
    else     last_d <= last_d_nxt;
  end
`else
  // An illegal D op blocks the fetch grant too, because it counts as a D request.
  assign grant_d = (state == IDLE) & d_req & ~illegal;
  assign grant_i = (state == IDLE) & i_Rd & ~d_req;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
          cnt_nxt   = '0;
          addr_nxt  = d_Addr;
          data_nxt  = d_DataIn;
          rd_nxt    = ~d_Wr;
          wr_nxt    = d_Wr;
        end else if (grant_i) begin
          state_nxt = BUSY_I;
          cnt_nxt   = '0;
          addr_nxt  = i_Addr;
          data_nxt  = '0;
          rd_nxt    = 1'b1;
          wr_nxt    = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (m_Done | m_err) begin
          state_nxt = IDLE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = FAULT;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      rd_q   <= rd_nxt;
      wr_q   <= wr_nxt;
    end
  end

  assign m_Addr   = addr_q;
  assign m_DataIn = data_q;
  assign m_Rd     = rd_q;
  assign m_Wr     = wr_q;

  // Requester-side outputs are forced low while rst is held so that the
  // input-derived terms (stalls, illegal-op error) also read zero in reset.
  assign i_Done     = ~rst & busy_i & (m_Done | m_err);
  assign d_Done     = ~rst & busy_d & (m_Done | m_err);
  assign i_DataOut  = i_Done ? m_DataOut : 16'h0000;
  assign d_DataOut  = d_Done ? m_DataOut : 16'h0000;
  assign d_CacheHit = d_Done & m_CacheHit;
  assign i_err      = ~rst & ((busy_i & m_err) | (state == FAULT));
  assign d_err      = ~rst & ((busy_d & m_err) | (state == FAULT) |
                              ((state == IDLE) & illegal));
  assign i_Stall    = ~rst & i_Rd & ~(busy_i & m_Done);
  assign d_Stall    = ~rst & d_req & ~(busy_d & m_Done);

  logic unused_fin;
  assign unused_fin = fin;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level model tracks who
// owns the memory, what request is in flight and how long it has waited, and
// predicts every output each cycle. Directed scenarios add literal checks.
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_Addr, i_DataOut;
  logic        i_Rd, i_Done, i_Stall, i_err;
  logic [15:0] d_Addr, d_DataIn, d_DataOut;
  logic        d_Rd, d_Wr, d_Done, d_Stall, d_CacheHit, d_err;
  logic [15:0] m_Addr, m_DataIn, m_DataOut;
  logic        m_Rd, m_Wr, m_Done, m_Stall, m_CacheHit, m_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_Addr(i_Addr), .i_Rd(i_Rd), .i_DataOut(i_DataOut), .i_Done(i_Done),
    .i_Stall(i_Stall), .i_err(i_err),
    .d_Addr(d_Addr), .d_DataIn(d_DataIn), .d_Rd(d_Rd), .d_Wr(d_Wr),
    .d_DataOut(d_DataOut), .d_Done(d_Done), .d_Stall(d_Stall),
    .d_CacheHit(d_CacheHit), .d_err(d_err),
    .m_Addr(m_Addr), .m_DataIn(m_DataIn), .m_Rd(m_Rd), .m_Wr(m_Wr),
    .m_DataOut(m_DataOut), .m_Done(m_Done), .m_Stall(m_Stall),
    .m_CacheHit(m_CacheHit), .m_err(m_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner 0 = nobody, 1 = fetch port, 2 = data port, 3 = faulted.
  int          owner;
  int          waited;
  logic [15:0] t_addr, t_data;
  logic        t_write;
  logic        last_was_d;

  logic i_done_prev, d_done_prev;
  logic resp_en, rand_new;
  int   resp_cnt, resp_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; waited = 0; t_addr = '0; t_data = '0; t_write = 1'b0;
    last_was_d = 1'b0;
  endtask

  task automatic check_outputs();
    logic on, done, e_id, e_dd, e_ie, e_de, e_mr, e_mw;
    on   = (owner == 1 || owner == 2);
    done = on && (m_Done || m_err);
    e_id = !rst && owner == 1 && done;
    e_dd = !rst && owner == 2 && done;
    e_ie = !rst && ((owner == 1 && m_err) || owner == 3);
    e_de = !rst && ((owner == 2 && m_err) || owner == 3 || (owner == 0 && d_Rd && d_Wr));
    e_mr = on && !t_write;
    e_mw = on && t_write;
    chk("i_Done", i_Done, e_id);
    chk("d_Done", d_Done, e_dd);
    chk("i_DataOut", i_DataOut, e_id ? m_DataOut : 16'h0);
    chk("d_DataOut", d_DataOut, e_dd ? m_DataOut : 16'h0);
    chk("d_CacheHit", d_CacheHit, e_dd && m_CacheHit);
    chk("i_err", i_err, e_ie);
    chk("d_err", d_err, e_de);
    chk("i_Stall", i_Stall, !rst && i_Rd && !(owner == 1 && m_Done));
    chk("d_Stall", d_Stall, !rst && (d_Rd || d_Wr) && !(owner == 2 && m_Done));
    chk("m_Rd", m_Rd, e_mr);
    chk("m_Wr", m_Wr, e_mw);
    if (e_mr || e_mw) chk("m_Addr", m_Addr, t_addr);
    if (e_mw) chk("m_DataIn", m_DataIn, t_data);
    i_done_prev = e_id;
    d_done_prev = e_dd;
  endtask

  task automatic model_advance();
    logic want_d, pick_d;
    if (rst) begin
      model_reset();
      return;
    end
    if (owner == 0) begin
      want_d = (d_Rd ^ d_Wr);
      if (d_Rd && d_Wr) begin
        // illegal op: nobody is granted
      end else if (want_d || i_Rd) begin
`ifdef MEM_ARB_RR_EN
        pick_d = want_d && (!i_Rd || !last_was_d);
`else
        pick_d = want_d;
`endif
        owner  = pick_d ? 2 : 1;
        waited = 0;
        t_addr  = pick_d ? d_Addr : i_Addr;
        t_data  = pick_d ? d_DataIn : 16'h0;
        t_write = pick_d && d_Wr;
        last_was_d = pick_d;
      end
    end else if (owner == 1 || owner == 2) begin
      if (m_Done || m_err) owner = 0;
      else begin
        waited++;
        if (waited >= TO) owner = 3;
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_advance();
    @(negedge clk);
  endtask

  task automatic drive_requesters();
    int r;
    if (i_Rd) begin
      if (i_done_prev) i_Rd = 1'b0;
    end else if (rand_new && $urandom_range(0, 2) == 0) begin
      i_Rd = 1'b1; i_Addr = 16'($urandom);
    end
    if (d_Rd && d_Wr) begin
      d_Rd = 1'b0; d_Wr = 1'b0;
    end else if (d_Rd || d_Wr) begin
      if (d_done_prev) begin d_Rd = 1'b0; d_Wr = 1'b0; end
    end else if (rand_new && $urandom_range(0, 2) == 0) begin
      r = $urandom_range(0, 9);
      d_Rd = (r == 0) || (r < 5);
      d_Wr = (r == 0) || (r >= 5);
      d_Addr = 16'($urandom); d_DataIn = 16'($urandom);
    end
  endtask

  task automatic drive_mem();
    int r;
    m_DataOut = 16'($urandom); m_CacheHit = 1'($urandom); m_Stall = 1'($urandom);
    m_Done = 1'b0; m_err = 1'b0;
    if (!resp_en) return;
    if (m_Rd || m_Wr) begin
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        r = $urandom_range(0, 7);
        m_err  = (r <= 1);
        m_Done = (r != 0);
      end
    end else begin
      resp_cnt = 0;
      resp_lat = $urandom_range(1, 6);
      m_Done = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((i_Rd || d_Rd || d_Wr) && k < 60) begin
      drive_requesters(); drive_mem(); step(); k++;
    end
    n_checks++;
    if (i_Rd || d_Rd || d_Wr) begin
      n_fail++;
      $display("FAIL %s drain: requests still pending after %0d cycles", name, k);
    end
    m_Done = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_Rd = 0; i_Addr = 0; d_Rd = 0; d_Wr = 0; d_Addr = 0; d_DataIn = 0;
    m_DataOut = 0; m_Done = 0; m_Stall = 0; m_CacheHit = 0; m_err = 0;
    resp_en = 1'b0; rand_new = 1'b0; resp_cnt = 0; resp_lat = 1;
    i_done_prev = 0; d_done_prev = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_Addr", m_Addr, 16'h0);
    chk("rst_m_DataIn", m_DataIn, 16'h0);
    chk("rst_m_Rd", m_Rd, 1'b0);
    chk("rst_i_err", i_err, 1'b0);
    step();

    // Single fetch, memory answers in the third busy cycle.
    i_Rd = 1'b1; i_Addr = 16'h0040;
    #1 chk("fetch_stall_idle", i_Stall, 1'b1);
    step();
    #1 chk("fetch_m_Rd", m_Rd, 1'b1);
    chk("fetch_m_Addr", m_Addr, 16'h0040);
    step(); step();
    m_Done = 1'b1; m_DataOut = 16'hBEEF;
    #1 chk("fetch_i_Done", i_Done, 1'b1);
    chk("fetch_i_DataOut", i_DataOut, 16'hBEEF);
    chk("fetch_i_Stall", i_Stall, 1'b0);
    step();
    i_Rd = 1'b0; m_Done = 1'b0;
    #1 chk("fetch_m_Rd_drop", m_Rd, 1'b0);
    step();

    // Collision: D wins first (last grant was I in either build).
    i_Rd = 1'b1; i_Addr = 16'h2000;
    d_Wr = 1'b1; d_Addr = 16'h1000; d_DataIn = 16'h1234;
    step();
    #1 chk("coll_m_Wr", m_Wr, 1'b1);
    chk("coll_m_DataIn", m_DataIn, 16'h1234);
    chk("coll_m_Addr", m_Addr, 16'h1000);
    m_Done = 1'b1;
    #1 chk("coll_d_Done", d_Done, 1'b1);
    chk("coll_i_Stall", i_Stall, 1'b1);
    step();
    d_Wr = 1'b0; m_Done = 1'b0;
    #1 chk("coll_idle_gap", m_Rd | m_Wr, 1'b0);
    step();
    #1 chk("coll_i_grant", m_Rd, 1'b1);
    chk("coll_i_addr", m_Addr, 16'h2000);
    m_Done = 1'b1;
    step();
    i_Rd = 1'b0; m_Done = 1'b0;
    step();

    // Illegal data op in IDLE.
    d_Rd = 1'b1; d_Wr = 1'b1;
    #1 chk("illegal_d_err", d_err, 1'b1);
    step();
    d_Rd = 1'b0; d_Wr = 1'b0;
    #1 chk("illegal_no_grant", m_Rd | m_Wr, 1'b0);
    step();

    // Memory error without m_Done on a data load.
    d_Rd = 1'b1; d_Addr = 16'h0100;
    step();
    m_err = 1'b1;
    #1 chk("merr_d_err", d_err, 1'b1);
    chk("merr_d_Done", d_Done, 1'b1);
    step();
    d_Rd = 1'b0; m_err = 1'b0;
    #1 chk("merr_idle", m_Rd, 1'b0);
    step();

    // Second collision after a D grant: round-robin favours I, fixed favours D.
    i_Rd = 1'b1; i_Addr = 16'h3000;
    d_Wr = 1'b1; d_Addr = 16'h1000; d_DataIn = 16'h5678;
    step();
`ifdef MEM_ARB_RR_EN
    #1 chk("coll2_i_first", m_Rd, 1'b1);
    chk("coll2_addr", m_Addr, 16'h3000);
`else
    #1 chk("coll2_d_first", m_Wr, 1'b1);
    chk("coll2_addr", m_Addr, 16'h1000);
`endif
    resp_en = 1'b1;
    drain("coll2");

    // Randomized traffic.
    rand_new = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      drive_requesters(); drive_mem(); step();
    end
    rand_new = 1'b0;
    drain("random");
    resp_en = 1'b0;
    step();

    // Asynchronous reset in the middle of a data transaction.
    d_Rd = 1'b1; d_Addr = 16'h0200;
    step();
    #1 chk("arst_busy", m_Rd, 1'b1);
    #1 rst = 1'b1;
    #1 chk("arst_m_Rd", m_Rd, 1'b0);
    chk("arst_m_Addr", m_Addr, 16'h0);
    chk("arst_d_Stall", d_Stall, 1'b0);
    model_reset();
    step();
    rst = 1'b0; d_Rd = 1'b0;
    step();
    i_Rd = 1'b1; i_Addr = 16'h0ABC;
    step();
    #1 chk("arst_regrant", m_Rd, 1'b1);
    chk("arst_regrant_addr", m_Addr, 16'h0ABC);
    resp_en = 1'b1;
    drain("arst");
    resp_en = 1'b0;
    step();

    // Watchdog: memory never answers.
    i_Rd = 1'b1; i_Addr = 16'h0777;
    step();
    for (int k = 0; k < TO; k++) step();
    #1 chk("to_m_Rd", m_Rd, 1'b0);
    chk("to_i_err", i_err, 1'b1);
    chk("to_d_err", d_err, 1'b1);
    d_Wr = 1'b1; d_Addr = 16'h0055;
    step(); step();
    #1 chk("to_ignored", m_Wr, 1'b0);
    chk("to_d_Done", d_Done, 1'b0);
    m_Done = 1'b1;
    step();
    m_Done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; i_Rd = 1'b0; d_Wr = 1'b0;
    #1 chk("to_cleared", i_err, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
